prio_arbiter_4: RTL and testbench
=================================

# prio_arbiter_4

Four-requester, fixed-priority resource arbiter that grants one shared datapath resource to at most one requester at a time. It uses the team's 4-to-2 priority encoding (requester 3 highest, code 3'b100 down to 3'b001, 3'b000 = none) and adds sequential behaviour: grant lock, a one-cycle release gap, and a hold-time limit with starvation masking. It sits between the requesting units and the shared resource, driving the resource's select/enable.

## Interface
- MAX_HOLD, default 8 — maximum consecutive GRANT cycles per grant; 0 disables the limit.
- CNT_W, default 4 — hold counter width; must satisfy 2^CNT_W > MAX_HOLD.
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst_n  input  1  reset; one clock, synchronous, active-low.
- i_req  input  4  request per requester, level, held until done.
- o_grant  output  4  one-hot grant (registered), all-zero when idle.
- o_gcode  output  3  encoded grant holder: 3'b100 req3, 3'b011 req2, 3'b010 req1, 3'b001 req0, 3'b000 none (registered).
- o_busy  output  1  high in GRANT and RELEASE states.
- o_timeout  output  1  one-cycle pulse when a grant is force-released.

## Operation
- Eligible requests: elig = i_req & ~mask. Winner = highest set index of elig.
- States: IDLE, GRANT, RELEASE.
- IDLE: if elig != 0, latch winner, set o_grant/o_gcode, clear hold counter, go GRANT; else stay, outputs zero.
- GRANT: grant stable regardless of other requests (no preemption, even by higher index).
  - Holder's i_req low at edge -> o_grant/o_gcode cleared, go RELEASE.
  - Else if MAX_HOLD != 0 and counter == MAX_HOLD-1 -> forced release: o_grant/o_gcode cleared, mask[holder] set, o_timeout pulses, go RELEASE.
  - Else counter increments.
- RELEASE: exactly one cycle, no grant; then IDLE. Requests arriving here are arbitrated in IDLE on the following edge.
- Mask: bit n cleared at any edge where i_req[n] is low; set only by forced release. A masked requester is ignored until it deasserts at least one cycle.
- Mask set and clear for the same bit cannot coincide (set requires i_req high).
- Counter saturates; never wraps in GRANT.

## Timing
- Reset (i_rst_n low at edge): state IDLE, o_grant 4'b0000, o_gcode 3'b000, o_busy 0, o_timeout 0, mask 0, counter 0. Reset mid-grant drops the grant on that edge with no RELEASE cycle and no o_timeout.
- Grant latency: i_req sampled high in IDLE at edge k -> o_grant valid after edge k (1 cycle).
- Hold: grant lasts N cycles where N = cycles holder's i_req stays high after grant, capped at MAX_HOLD.
- Release: holder drop sampled at edge k -> grant low after k, RELEASE during k..k+1, next grant earliest after edge k+2.
- Back-to-back minimum grant spacing: one idle (RELEASE) cycle plus arbitration in IDLE cycle.
- o_timeout high for the single cycle following the forced-release edge, concurrent with RELEASE.
- o_gcode always consistent with o_grant in the same cycle.
- Simultaneous requests in IDLE: highest index wins; losers remain pending, no memory of order.

## Test plan
- Single request: i_req=4'b0010 for 3 cycles then 0 -> o_grant=4'b0010, o_gcode=3'b010 for 3 cycles, 1 RELEASE cycle with o_busy=1, then idle zeros.
- Simultaneous: i_req=4'b1011 from IDLE -> o_grant=4'b1000, o_gcode=3'b100; after req3 drops, RELEASE, then o_grant=4'b0010.
- No preemption: req0 granted, then req3 rises -> o_grant stays 4'b0001 until req0 drops; req3 granted two edges after drop.
- Timeout (MAX_HOLD=8): req2 held high 20 cycles, others low -> grant for exactly 8 cycles, o_timeout pulse, no re-grant to req2 while high; req2 low one cycle then high -> granted again.
- Timeout with competitor: req3 held, req1 high -> after 8 grant cycles and RELEASE, o_grant=4'b0010 despite req3 still high.
- Reset mid-grant: i_rst_n low during GRANT -> all outputs zero next edge, mask 0; after release of reset, pending i_req=4'b0100 granted one edge later.

Source files
------------

// File: rtl/prio_arbiter_4_if.sv
// Request/grant bundle between the requesting units and the fixed-priority
// arbiter that owns the shared datapath resource.
interface prio_arbiter_4_if;
   logic [3:0] i_req;      // level request per requester, held until done
   logic [3:0] o_grant;    // one-hot grant, all-zero when nobody holds the resource
   logic [2:0] o_gcode;    // encoded holder: 3'b100 req3 .. 3'b001 req0, 3'b000 none
   logic       o_busy;     // resource owned or in its release gap
   logic       o_timeout;  // one-cycle pulse after a forced release

   // Requesting side drives requests and observes the grant
   modport master (
      output i_req,
      input  o_grant,
      input  o_gcode,
      input  o_busy,
      input  o_timeout
   );

   // Arbiter side
   modport slave (
      input  i_req,
      output o_grant,
      output o_gcode,
      output o_busy,
      output o_timeout
   );
endinterface

// File: rtl/prio_arbiter_4.sv
// Four-requester fixed-priority arbiter with grant lock, a one-cycle release
// gap and an optional hold-time limit. A requester that is force-released is
// masked until it drops its request for at least one cycle, so a competitor
// gets the resource instead of the same unit re-winning immediately.
module prio_arbiter_4 #(
   parameter int MAX_HOLD = 8,   // max consecutive grant cycles, 0 = unlimited
   parameter int CNT_W    = 4    // hold counter width, 2**CNT_W > MAX_HOLD
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   prio_arbiter_4_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Counter value seen during the last permitted grant cycle
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_q,   state_nxt;
   logic [3:0]       grant_q,   grant_nxt;
   logic [2:0]       gcode_q,   gcode_nxt;
   logic [1:0]       holder_q,  holder_nxt;
   logic [CNT_W-1:0] cnt_q,     cnt_nxt;
   logic [3:0]       mask_q,    mask_nxt;
   logic             timeout_q, timeout_nxt;

   logic [3:0]       elig;
   logic [1:0]       win_idx;
   logic             holder_req;
   logic             hold_expired;

   // Index of the highest set request bit; requester 3 has top priority
   function automatic logic [1:0] prio_index(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int n = 0; n < 4; n++) begin
         if (r[n]) idx = 2'(n);
      end
      return idx;
   endfunction

   // Team 4-to-2 grant code: index + 1, leaving 3'b000 for "no holder"
   function automatic logic [2:0] grant_code(input logic [1:0] idx);
      return {1'b0, idx} + 3'd1;
   endfunction

   // One-hot select line for the resource
   function automatic logic [3:0] onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Hold counter increments but sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   assign elig         = bus.i_req & ~mask_q;
   assign win_idx      = prio_index(elig);
   assign holder_req   = bus.i_req[holder_q];
   assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

   // State register plus the registered grant, code, counter, mask and pulse
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         grant_q   <= 4'b0000;
         gcode_q   <= 3'b000;
         holder_q  <= 2'd0;
         cnt_q     <= '0;
         mask_q    <= 4'b0000;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         grant_q   <= grant_nxt;
         gcode_q   <= gcode_nxt;
         holder_q  <= holder_nxt;
         cnt_q     <= cnt_nxt;
         mask_q    <= mask_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   // Next-state logic: arbitrate in IDLE, lock in GRANT, one gap cycle in RELEASE
   always_comb begin
      state_nxt   = state_q;
      grant_nxt   = grant_q;
      gcode_nxt   = gcode_q;
      holder_nxt  = holder_q;
      cnt_nxt     = cnt_q;
      timeout_nxt = 1'b0;
      // A requester that drops its request earns back eligibility
      mask_nxt    = mask_q & bus.i_req;

      case (state_q)
         IDLE: begin
            grant_nxt = 4'b0000;
            gcode_nxt = 3'b000;
            if (elig != 4'b0000) begin
               holder_nxt = win_idx;
               grant_nxt  = onehot(win_idx);
               gcode_nxt  = grant_code(win_idx);
               cnt_nxt    = '0;
               state_nxt  = GRANT;
            end
         end

         GRANT: begin
            // No preemption: only the holder's own request or the hold
            // limit can end the grant
            if (!holder_req) begin
               grant_nxt = 4'b0000;
               gcode_nxt = 3'b000;
               state_nxt = RELEASE;
            end else if (hold_expired) begin
               grant_nxt            = 4'b0000;
               gcode_nxt            = 3'b000;
               mask_nxt[holder_q]   = 1'b1;
               timeout_nxt          = 1'b1;
               state_nxt            = RELEASE;
            end else begin
               cnt_nxt = sat_inc(cnt_q);
            end
         end

         RELEASE: begin
            grant_nxt = 4'b0000;
            gcode_nxt = 3'b000;
            state_nxt = IDLE;
         end

         default: begin
            grant_nxt = 4'b0000;
            gcode_nxt = 3'b000;
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs: registered grant/code/pulse, busy decoded from the state
   always_comb begin
      bus.o_grant   = grant_q;
      bus.o_gcode   = gcode_q;
      bus.o_timeout = timeout_q;
      bus.o_busy    = (state_q == GRANT) || (state_q == RELEASE);
   end

endmodule

// File: tb/tb_prio_arbiter_4.sv
// Bench for prio_arbiter_4: directed scenarios with literal expectations and a
// randomized run checked against a cycle-level ownership model.
module tb_prio_arbiter_4;
   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   prio_arbiter_4_if bus ();

   prio_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Observed outputs packed as {grant, gcode, busy, timeout}
   logic [8:0] obs;
   assign obs = {bus.o_grant, bus.o_gcode, bus.o_busy, bus.o_timeout};

   // Reference model: who owns the resource, for how many cycles, gap flag,
   // per-requester mask and the timeout pulse.
   int         m_owner = -1;
   int         m_held  = 0;
   bit         m_gap   = 1'b0;
   logic [3:0] m_mask  = 4'b0000;
   bit         m_to    = 1'b0;

   always @(posedge clk) begin
      int         o;
      int         h;
      bit         g;
      bit         t;
      logic [3:0] mk;
      o  = m_owner;
      h  = m_held;
      g  = m_gap;
      t  = 1'b0;
      mk = m_mask & bus.i_req;
      if (!rst_n) begin
         o = -1; h = 0; g = 1'b0; mk = 4'b0000;
      end else if (m_owner >= 0) begin
         if (!bus.i_req[m_owner]) begin
            o = -1; g = 1'b1;
         end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
            mk[m_owner] = 1'b1; t = 1'b1; o = -1; g = 1'b1;
         end else begin
            h = m_held + 1;
         end
      end else if (m_gap) begin
         g = 1'b0;
      end else begin
         for (int n = 0; n < 4; n++)
            if (bus.i_req[n] && !m_mask[n]) begin o = n; h = 1; end
      end
      m_owner <= o;
      m_held  <= h;
      m_gap   <= g;
      m_mask  <= mk;
      m_to    <= t;
   end

   // Advance one active edge and return to the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.i_req = 4'b1111;
      rst_n = 1'b0;
      tick();
      tick();
      vectors++;
      if (obs !== 9'b0000_000_0_0) begin
         miscompares++;
         $display("FAIL reset: got %b required %b", obs, 9'b0000_000_0_0);
      end
      bus.i_req = 4'b0000;
      rst_n = 1'b1;
      tick();
      vectors++;
      if (obs !== 9'b0000_000_0_0) begin
         miscompares++;
         $display("FAIL reset_idle: got %b required %b", obs, 9'b0000_000_0_0);
      end
   endtask

   task automatic test_single();
      bus.i_req = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (obs !== 9'b0010_010_1_0) begin
            miscompares++;
            $display("FAIL single_grant[%0d]: got %b required %b", i, obs, 9'b0010_010_1_0);
         end
      end
      bus.i_req = 4'b0000;
      tick();
      vectors++;
      if (obs !== 9'b0000_000_1_0) begin
         miscompares++;
         $display("FAIL single_release: got %b required %b", obs, 9'b0000_000_1_0);
      end
      tick();
      vectors++;
      if (obs !== 9'b0000_000_0_0) begin
         miscompares++;
         $display("FAIL single_idle: got %b required %b", obs, 9'b0000_000_0_0);
      end
   endtask

   task automatic test_simultaneous();
      logic [8:0] exp [5];
      exp[0] = 9'b1000_100_1_0;
      exp[1] = 9'b1000_100_1_0;
      exp[2] = 9'b0000_000_1_0;
      exp[3] = 9'b0000_000_0_0;
      exp[4] = 9'b0010_010_1_0;
      for (int i = 0; i < 5; i++) begin
         bus.i_req = (i < 2) ? 4'b1011 : 4'b0011;
         tick();
         vectors++;
         if (obs !== exp[i]) begin
            miscompares++;
            $display("FAIL simultaneous[%0d]: got %b required %b", i, obs, exp[i]);
         end
      end
      bus.i_req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_no_preempt();
      logic [8:0] exp [7];
      logic [3:0] req [7];
      req[0] = 4'b0001; exp[0] = 9'b0001_001_1_0;
      req[1] = 4'b1001; exp[1] = 9'b0001_001_1_0;
      req[2] = 4'b1001; exp[2] = 9'b0001_001_1_0;
      req[3] = 4'b1001; exp[3] = 9'b0001_001_1_0;
      req[4] = 4'b1000; exp[4] = 9'b0000_000_1_0;
      req[5] = 4'b1000; exp[5] = 9'b0000_000_0_0;
      req[6] = 4'b1000; exp[6] = 9'b1000_100_1_0;
      for (int i = 0; i < 7; i++) begin
         bus.i_req = req[i];
         tick();
         vectors++;
         if (obs !== exp[i]) begin
            miscompares++;
            $display("FAIL no_preempt[%0d]: got %b required %b", i, obs, exp[i]);
         end
      end
      bus.i_req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      logic [8:0] e;
      bus.i_req = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i < MAX_HOLD)       e = 9'b0100_011_1_0;
         else if (i == MAX_HOLD) e = 9'b0000_000_1_1;
         else                    e = 9'b0000_000_0_0;
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL timeout[%0d]: got %b required %b", i, obs, e);
         end
      end
      bus.i_req = 4'b0000;
      tick();
      bus.i_req = 4'b0100;
      tick();
      vectors++;
      if (obs !== 9'b0100_011_1_0) begin
         miscompares++;
         $display("FAIL timeout_regrant: got %b required %b", obs, 9'b0100_011_1_0);
      end
      bus.i_req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_timeout_competitor();
      logic [8:0] e;
      bus.i_req = 4'b1000;
      tick();
      bus.i_req = 4'b1010;
      for (int i = 0; i < MAX_HOLD + 3; i++) begin
         if (i < MAX_HOLD)           e = 9'b1000_100_1_0;
         else if (i == MAX_HOLD)     e = 9'b0000_000_1_1;
         else if (i == MAX_HOLD + 1) e = 9'b0000_000_0_0;
         else                        e = 9'b0010_010_1_0;
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL timeout_comp[%0d]: got %b required %b", i, obs, e);
         end
         tick();
      end
      bus.i_req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_grant();
      bus.i_req = 4'b0100;
      tick();
      vectors++;
      if (obs !== 9'b0100_011_1_0) begin
         miscompares++;
         $display("FAIL rst_mid_pre: got %b required %b", obs, 9'b0100_011_1_0);
      end
      rst_n = 1'b0;
      tick();
      vectors++;
      if (obs !== 9'b0000_000_0_0) begin
         miscompares++;
         $display("FAIL rst_mid_drop: got %b required %b", obs, 9'b0000_000_0_0);
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if (obs !== 9'b0100_011_1_0) begin
         miscompares++;
         $display("FAIL rst_mid_regrant: got %b required %b", obs, 9'b0100_011_1_0);
      end
      // Force a timeout so req2 is masked, then reset must clear the mask
      for (int i = 0; i < MAX_HOLD; i++) tick();
      vectors++;
      if (obs !== 9'b0000_000_1_1) begin
         miscompares++;
         $display("FAIL rst_mask_to: got %b required %b", obs, 9'b0000_000_1_1);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      vectors++;
      if (obs !== 9'b0100_011_1_0) begin
         miscompares++;
         $display("FAIL rst_mask_clear: got %b required %b", obs, 9'b0100_011_1_0);
      end
      bus.i_req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_random();
      logic [3:0] flip;
      logic [3:0] eg;
      logic [2:0] ec;
      logic [8:0] e;
      for (int i = 0; i < 1500; i++) begin
         flip = 4'b0000;
         for (int n = 0; n < 4; n++) flip[n] = ($urandom_range(0, 5) == 0);
         bus.i_req = bus.i_req ^ flip;
         rst_n = ($urandom_range(0, 99) != 0);
         tick();
         eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         ec = (m_owner >= 0) ? 3'(m_owner + 1) : 3'b000;
         e  = {eg, ec, (m_owner >= 0) || m_gap, m_to};
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL random[%0d]: req %b got %b required %b", i, bus.i_req, obs, e);
         end
      end
      rst_n = 1'b1;
      bus.i_req = 4'b0000;
      tick();
      tick();
   endtask

   initial begin
      bus.i_req = 4'b0000;
      @(negedge clk);
      test_reset();
      test_single();
      test_simultaneous();
      test_no_preempt();
      test_timeout();
      test_timeout_competitor();
      test_reset_mid_grant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
